seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Parametrised multiplexed 7-segment scan driver: time-multiplexes NUM_DIGITS segment patterns onto one shared segment bus.
//  Adds anti-ghost dead time, PWM brightness, per-digit enable/blink and a double-buffered frame update with valid/ready handshake.
//  Sits between display-content logic (BCD/7-seg encoders) and board pins; runs on the display clock clk_out.
// PARAMETERS
//  NUM_DIGITS     8    number of digits (>=1)
//  SEG_W          8    segment bits per digit (a..g + dp)
//  SCAN_DIV       128  clk_out cycles per digit slot (> DEAD_CYC)
//  DEAD_CYC       4    blank cycles at start of each slot
//  BRIGHT_W       4    brightness width
//  BLINK_FRAMES   250  frames per blink half-period (>=1)
//  SEG_ACT_LOW    1    1: segment lit when display_out bit = 0
//  DIG_ACT_LOW    1    1: digit selected when seg_control bit = 0
// PORTS
//  clk_out      in   1                  display clock
//  reset        in   1                  async, active-low
//  digits_in    in   NUM_DIGITS*SEG_W   digit k pattern at [k*SEG_W +: SEG_W], active-high lit
//  upd_valid    in   1                  new frame offered
//  upd_ready    out  1                  staging buffer empty
//  digit_en     in   NUM_DIGITS         0 = digit always blank
//  blink_mask   in   NUM_DIGITS         1 = digit blinks
//  brightness   in   BRIGHT_W           0 = off, all-ones = full on
//  display_out  out  SEG_W              shared segment bus (polarity per SEG_ACT_LOW)
//  seg_control  out  NUM_DIGITS         one-hot digit select (polarity per DIG_ACT_LOW); bit k = digit k
//  frame_tick   out  1                  1-cycle pulse at frame boundary
// BEHAVIOUR
//  Clock/reset: clk_out; reset async active-low; all state cleared immediately on assertion, including mid-slot.
//  Reset values:
//   - display_out and seg_control all inactive; frame_tick = 0; upd_ready = 1.
//   - slot_cnt = 0, dig_idx = 0, blink_phase = 0.
//   - shadow and staging buffers = 0 (unlit).
//  Counters:
//   - slot_cnt runs 0..SCAN_DIV-1; on wrap, dig_idx increments and wraps NUM_DIGITS-1 -> 0.
//   - Frame boundary = slot_cnt==SCAN_DIV-1 && dig_idx==NUM_DIGITS-1.
//   - frame_cnt counts boundaries 0..BLINK_FRAMES-1; on wrap, blink_phase toggles.
//  Slot activity:
//   - brt is sampled at slot_cnt==0 and held for the slot.
//   - Active iff slot_cnt>=DEAD_CYC, digit_en[dig_idx], !(blink_mask[dig_idx] && blink_phase),
//     and (brt==all-ones || ((slot_cnt-DEAD_CYC) mod 2^BRIGHT_W) < brt).
//   - Active: seg_control selects dig_idx only; display_out = shadow[dig_idx], polarity applied.
//   - Inactive: seg_control all inactive; display_out all unlit.
//  Output timing:
//   - display_out and seg_control are registered: latency 1 cycle from counter state.
//   - Never two digits selected; seg_control always inactive for the full dead window of every slot.
//  Handshake:
//   - Transfer when upd_valid && upd_ready: digits_in -> staging, staging_full=1, upd_ready=0 next cycle.
//   - At frame boundary with staging_full: shadow <= staging, staging_full=0.
//   - Capture coinciding with a boundary is held in staging until the next boundary; no bypass.
//   - The displayed frame is never torn.
//  frame_tick: registered, high for the cycle after the boundary cycle.
//  digit_en and blink_mask: live; no sampling.
//  NUM_DIGITS==1: dig_idx is constant 0; every slot end is a frame boundary.
// STRUCTURE
//  Package seg_scan_pkg:
//   - polarity helper function apply_pol(value, act_low).
//   - blank constants.
//   - localparam width helper clog2_min1 for counter widths.
//  Sub-module seg_scan_timer:
//   - contains slot_cnt, dig_idx, frame_cnt and blink_phase.
//   - outputs slot position, digit index, boundary strobe and blink_phase.
//  Top level: staging/shadow buffers, handshake, activity decode, output registers.
// TESTING (bench params: NUM_DIGITS=4, SCAN_DIV=16, DEAD_CYC=2, BRIGHT_W=2, BLINK_FRAMES=2, both ACT_LOW=1)
//  1 Reset
//    - Stimulus: reset low, then release; no update.
//    - Required: seg_control=4'b1111 and display_out=8'hFF during reset;
//      after release, frame_tick every 64 cycles; upd_ready=1.
//  2 Update
//    - Stimulus: upd_valid with digits {8'h06,8'h5B,8'h4F,8'h66}; brightness=3; all enabled.
//    - Required: upd_ready drops next cycle; at the next boundary, digit 0 shows ~8'h66;
//      upd_ready returns high.
//  3 Scan/PWM
//    - Stimulus: brightness=3, then 1.
//    - brightness=3: each slot gives 2 blank cycles then 14 active.
//    - brightness=1: active only at slot offsets 2,6,10,14.
//    - brightness=0: seg_control stays 4'b1111.
//  4 Blink/enable
//    - Stimulus: blink_mask=4'b0010, digit_en=4'b1011.
//    - Required: digit 2 never selected; digit 1 selected in frames 0-1, dark in frames 2-3, repeating.
//  5 Handshake boundary
//    - Stimulus: upd_valid in the boundary cycle, then a second upd_valid while staging is full.
//    - Required: first data appears one frame later; second offer waits (upd_ready=0) until that transfer.
//  6 Reset mid-slot
//    - Stimulus: assert reset at slot offset 9 of digit 2.
//    - Required: outputs go inactive the same cycle; restart from digit 0 blank frame.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared helpers for the multiplexed 7-segment scan driver: polarity
// application, inactive ("blank") bus values and counter width sizing.
package seg_scan_pkg;

    // Widest bus the polarity helpers handle. Callers zero-extend their
    // value in and truncate the result back to their own width.
    localparam int POL_MAX_W = 64;

    // Inactive levels for an active-low and an active-high output.
    localparam logic [POL_MAX_W-1:0] BLANK_ACT_LOW  = '1;
    localparam logic [POL_MAX_W-1:0] BLANK_ACT_HIGH = '0;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Convert an active-high pattern into pin levels.
    function automatic logic [POL_MAX_W-1:0] apply_pol(
        input logic [POL_MAX_W-1:0] value,
        input bit                   act_low
    );
        return act_low ? ~value : value;
    endfunction

    // All-inactive pin level for the given polarity.
    function automatic logic [POL_MAX_W-1:0] blank_val(input bit act_low);
        return act_low ? BLANK_ACT_LOW : BLANK_ACT_HIGH;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Frame-update channel: the content source offers a full set of digit
// patterns with upd_valid; the driver accepts it when upd_ready is high.
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8,
    parameter int SEG_W      = 8
);
    // Digit k occupies [k*SEG_W +: SEG_W], active-high lit.
    logic [NUM_DIGITS*SEG_W-1:0] digits_in;
    logic                        upd_valid;
    logic                        upd_ready;

    modport master (
        output digits_in,
        output upd_valid,
        input  upd_ready
    );

    modport slave (
        input  digits_in,
        input  upd_valid,
        output upd_ready
    );
endinterface

// File: rtl/seg_scan_timer.sv
// Scan timebase: position inside the digit slot, current digit, frame
// counter and the blink half-period phase derived from it.
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 128,
    parameter int BLINK_FRAMES = 250,
    localparam int SLOT_W      = clog2_min1(SCAN_DIV),
    localparam int DIG_W       = clog2_min1(NUM_DIGITS)
) (
    input  logic              clk_out,
    input  logic              reset,
    output logic [SLOT_W-1:0] slot_cnt,
    output logic [DIG_W-1:0]  dig_idx,
    output logic              boundary,
    output logic              blink_phase
);

    localparam int FRAME_W = clog2_min1(BLINK_FRAMES);

    logic [SLOT_W-1:0]  slot_cnt_reg, slot_cnt_next;
    logic [DIG_W-1:0]   dig_idx_reg, dig_idx_next;
    logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;
    logic               blink_phase_reg, blink_phase_next;
    logic               slot_end;
    logic               dig_last;
    logic               frame_last;

    assign slot_end   = (slot_cnt_reg == SLOT_W'(SCAN_DIV - 1));
    // With a single digit the index register never leaves 0, so every
    // slot end is also a frame end.
    assign dig_last   = (dig_idx_reg == DIG_W'(NUM_DIGITS - 1));
    assign frame_last = (frame_cnt_reg == FRAME_W'(BLINK_FRAMES - 1));

    // Next-state: slot counter always runs, digit advances at slot end,
    // frame counter and blink phase advance at frame end.
    always_comb begin
        slot_cnt_next    = slot_end ? '0 : slot_cnt_reg + 1'b1;
        dig_idx_next     = dig_idx_reg;
        frame_cnt_next   = frame_cnt_reg;
        blink_phase_next = blink_phase_reg;
        if (slot_end) begin
            dig_idx_next = dig_last ? '0 : dig_idx_reg + 1'b1;
            if (dig_last) begin
                if (frame_last) begin
                    frame_cnt_next   = '0;
                    blink_phase_next = ~blink_phase_reg;
                end else begin
                    frame_cnt_next = frame_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Timebase registers; cleared immediately when reset is asserted.
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            slot_cnt_reg    <= '0;
            dig_idx_reg     <= '0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            slot_cnt_reg    <= slot_cnt_next;
            dig_idx_reg     <= dig_idx_next;
            frame_cnt_reg   <= frame_cnt_next;
            blink_phase_reg <= blink_phase_next;
        end
    end

    assign slot_cnt    = slot_cnt_reg;
    assign dig_idx     = dig_idx_reg;
    assign boundary    = slot_end && dig_last;
    assign blink_phase = blink_phase_reg;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver. Shows one digit per slot on a shared
// segment bus, blanks the start of every slot against ghosting, applies PWM
// brightness, per-digit enable and blink, and swaps in new frames only at
// frame boundaries through a staging/shadow buffer pair.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SEG_W        = 8,
    parameter int SCAN_DIV     = 128,
    parameter int DEAD_CYC     = 4,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 250,
    parameter int SEG_ACT_LOW  = 1,
    parameter int DIG_ACT_LOW  = 1
) (
    input  logic                  clk_out,
    input  logic                  reset,
    seg_scan_driver_if.slave      upd_bus,
    input  logic [NUM_DIGITS-1:0] digit_en,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [SEG_W-1:0]      display_out,
    output logic [NUM_DIGITS-1:0] seg_control,
    output logic                  frame_tick
);

    localparam int SLOT_W = clog2_min1(SCAN_DIV);
    localparam int DIG_W  = clog2_min1(NUM_DIGITS);
    localparam int OFF_W  = SLOT_W + BRIGHT_W;

    localparam logic [SEG_W-1:0]      SEG_OFF = SEG_W'(blank_val(SEG_ACT_LOW != 0));
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = NUM_DIGITS'(blank_val(DIG_ACT_LOW != 0));

    genvar gi;

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0] slot_cnt;
    logic [DIG_W-1:0]  dig_idx;
    logic              boundary;
    logic              blink_phase;

    seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk_out     (clk_out),
        .reset       (reset),
        .slot_cnt    (slot_cnt),
        .dig_idx     (dig_idx),
        .boundary    (boundary),
        .blink_phase (blink_phase)
    );

    // ------------------------------------------------------------------
    // Frame buffers: staging takes the offered frame, shadow is what is
    // displayed. Shadow only changes at a frame boundary, so a frame is
    // never shown half old and half new.
    // ------------------------------------------------------------------
    logic                        staging_full_reg, staging_full_next;
    logic                        take_upd;
    logic                        load_shadow;
    logic [NUM_DIGITS*SEG_W-1:0] shadow_flat;

    assign take_upd          = upd_bus.upd_valid && !staging_full_reg;
    assign load_shadow       = boundary && staging_full_reg;
    assign upd_bus.upd_ready = !staging_full_reg;

    // A capture in the boundary cycle sees staging empty and no load, so
    // it waits in staging for the following boundary.
    always_comb begin
        staging_full_next = staging_full_reg;
        if (load_shadow) begin
            staging_full_next = 1'b0;
        end
        if (take_upd) begin
            staging_full_next = 1'b1;
        end
    end

    // Staging occupancy flag.
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            staging_full_reg <= 1'b0;
        end else begin
            staging_full_reg <= staging_full_next;
        end
    end

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_buf
            logic [SEG_W-1:0] staging_reg;
            logic [SEG_W-1:0] shadow_reg;

            // Per-digit staging capture and boundary copy into shadow.
            always_ff @(posedge clk_out or negedge reset) begin
                if (!reset) begin
                    staging_reg <= '0;
                    shadow_reg  <= '0;
                end else begin
                    if (take_upd) begin
                        staging_reg <= upd_bus.digits_in[gi*SEG_W +: SEG_W];
                    end
                    if (load_shadow) begin
                        shadow_reg <= staging_reg;
                    end
                end
            end

            assign shadow_flat[gi*SEG_W +: SEG_W] = shadow_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Activity decode
    // ------------------------------------------------------------------
    logic [BRIGHT_W-1:0]   brt_reg;
    logic [BRIGHT_W-1:0]   brt_eff;
    logic [BRIGHT_W-1:0]   pwm_pos;
    logic                  in_dead;
    logic                  pwm_on;
    logic                  digit_on;
    logic                  active;
    logic [SEG_W-1:0]      seg_pattern;
    logic [NUM_DIGITS-1:0] dig_onehot;

    // Brightness is latched at slot start; offset 0 uses the live value so
    // a slot never mixes two brightness settings.
    assign brt_eff = (slot_cnt == '0) ? brightness : brt_reg;

    // Hold brightness for the rest of the slot.
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            brt_reg <= '0;
        end else if (slot_cnt == '0) begin
            brt_reg <= brightness;
        end
    end

    // PWM position counts from the end of the dead window, modulo 2^BRIGHT_W.
    assign pwm_pos  = BRIGHT_W'({{BRIGHT_W{1'b0}}, slot_cnt} - OFF_W'(DEAD_CYC));
    assign in_dead  = (slot_cnt < SLOT_W'(DEAD_CYC));
    assign pwm_on   = (&brt_eff) || (pwm_pos < brt_eff);
    assign digit_on = digit_en[dig_idx] && !(blink_mask[dig_idx] && blink_phase);
    assign active   = !in_dead && digit_on && pwm_on;

    assign seg_pattern = shadow_flat[dig_idx*SEG_W +: SEG_W];

    // One-hot select for the current digit.
    always_comb begin
        dig_onehot          = '0;
        dig_onehot[dig_idx] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Output registers: one cycle behind the timebase.
    // ------------------------------------------------------------------
    logic [SEG_W-1:0]      display_out_reg, display_out_next;
    logic [NUM_DIGITS-1:0] seg_control_reg, seg_control_next;
    logic                  frame_tick_reg;

    // Drive the selected digit only while active; otherwise all pins idle.
    always_comb begin
        display_out_next = SEG_OFF;
        seg_control_next = DIG_OFF;
        if (active) begin
            display_out_next = SEG_W'(apply_pol(POL_MAX_W'(seg_pattern), SEG_ACT_LOW != 0));
            seg_control_next = NUM_DIGITS'(apply_pol(POL_MAX_W'(dig_onehot), DIG_ACT_LOW != 0));
        end
    end

    // Pin registers and the frame tick, forced idle as soon as reset asserts.
    always_ff @(posedge clk_out or negedge reset) begin
        if (!reset) begin
            display_out_reg <= SEG_OFF;
            seg_control_reg <= DIG_OFF;
            frame_tick_reg  <= 1'b0;
        end else begin
            display_out_reg <= display_out_next;
            seg_control_reg <= seg_control_next;
            frame_tick_reg  <= boundary;
        end
    end

    assign display_out = display_out_reg;
    assign seg_control = seg_control_reg;
    assign frame_tick  = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus randomized content,
// brightness, enable and blink, scored every cycle against a model that
// derives slot, digit and frame from the cycle count since reset release.
module tb_seg_scan_driver;

    localparam int ND        = 4;
    localparam int SW        = 8;
    localparam int SD        = 16;
    localparam int DC        = 2;
    localparam int BW        = 2;
    localparam int BF        = 2;
    localparam int FRAME_CYC = ND * SD;
    localparam int BRT_FULL  = (1 << BW) - 1;

    logic          clk_out = 1'b0;
    logic          reset   = 1'b0;
    logic [ND-1:0] digit_en;
    logic [ND-1:0] blink_mask;
    logic [BW-1:0] brightness;
    logic [SW-1:0] display_out;
    logic [ND-1:0] seg_control;
    logic          frame_tick;

    seg_scan_driver_if #(.NUM_DIGITS(ND), .SEG_W(SW)) upd_bus ();

    seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .SEG_W        (SW),
        .SCAN_DIV     (SD),
        .DEAD_CYC     (DC),
        .BRIGHT_W     (BW),
        .BLINK_FRAMES (BF),
        .SEG_ACT_LOW  (1),
        .DIG_ACT_LOW  (1)
    ) dut (
        .clk_out     (clk_out),
        .reset       (reset),
        .upd_bus     (upd_bus),
        .digit_en    (digit_en),
        .blink_mask  (blink_mask),
        .brightness  (brightness),
        .display_out (display_out),
        .seg_control (seg_control),
        .frame_tick  (frame_tick)
    );

    always #5 clk_out = ~clk_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            cyc = 0;
    logic [SW-1:0] shadow_m [ND];
    logic [SW-1:0] stage_m  [ND];
    bit            staged_m = 1'b0;
    int            brt_m = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h cyc=%0d t=%0t", tag, got, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        staged_m = 1'b0;
        brt_m    = 0;
        for (int k = 0; k < ND; k++) begin
            shadow_m[k] = '0;
            stage_m[k]  = '0;
        end
    endtask

    // Scoreboard: at every edge predict the registered outputs from the
    // counter position implied by the cycle count, then compare just after.
    initial begin
        int            slot;
        int            dig;
        int            frame;
        bit            phase;
        bit            active;
        bit            bnd;
        bit            ready_old;
        logic [ND-1:0] one;
        logic [ND-1:0] exp_sc;
        logic [SW-1:0] exp_do;
        model_reset();
        forever begin
            @(posedge clk_out);
            if (!reset) begin
                model_reset();
            end else begin
                slot  = cyc % SD;
                dig   = (cyc / SD) % ND;
                frame = cyc / FRAME_CYC;
                phase = ((frame / BF) % 2) == 1;
                if (slot == 0) brt_m = int'(brightness);
                active = (slot >= DC) && digit_en[dig] && !(blink_mask[dig] && phase)
                         && ((brt_m == BRT_FULL) || (((slot - DC) % (1 << BW)) < brt_m));
                one    = 1;
                exp_sc = active ? ~(one << dig) : {ND{1'b1}};
                exp_do = active ? ~shadow_m[dig] : {SW{1'b1}};
                bnd    = (slot == SD - 1) && (dig == ND - 1);
                ready_old = !staged_m;
                if (bnd && staged_m) begin
                    shadow_m = stage_m;
                    staged_m = 1'b0;
                    $display("LOAD  cyc=%0d frame=%0d shadow now %h %h %h %h", cyc, frame,
                             shadow_m[3], shadow_m[2], shadow_m[1], shadow_m[0]);
                end
                if (upd_bus.upd_valid && ready_old) begin
                    for (int k = 0; k < ND; k++) stage_m[k] = upd_bus.digits_in[k*SW +: SW];
                    staged_m = 1'b1;
                    $display("UPD   cyc=%0d accepted digits=%h", cyc, upd_bus.digits_in);
                end
                cyc++;
                #1;
                chk("seg_control", 32'(seg_control), 32'(exp_sc));
                chk("display_out", 32'(display_out), 32'(exp_do));
                chk("frame_tick", 32'(frame_tick), 32'(bnd));
                chk("upd_ready", 32'(upd_bus.upd_ready), 32'(!staged_m));
            end
        end
    end

    // Advance to the negedge where the counter sits at frame position p.
    task automatic wait_phase(input int p);
        for (int i = 0; i < FRAME_CYC && (cyc % FRAME_CYC) != p; i++) @(negedge clk_out);
    endtask

    task automatic offer(input logic [ND*SW-1:0] data, input int hold);
        upd_bus.digits_in = data;
        upd_bus.upd_valid = 1'b1;
        repeat (hold) @(negedge clk_out);
        upd_bus.upd_valid = 1'b0;
    endtask

    initial begin
        upd_bus.digits_in = '0;
        upd_bus.upd_valid = 1'b0;
        digit_en          = '1;
        blink_mask        = '0;
        brightness        = 2'd3;

        // 1: reset state, then two frames with no update
        repeat (3) @(negedge clk_out);
        chk("rst_seg_control", 32'(seg_control), 32'h0000_000F);
        chk("rst_display_out", 32'(display_out), 32'h0000_00FF);
        chk("rst_frame_tick", 32'(frame_tick), 32'h0);
        chk("rst_upd_ready", 32'(upd_bus.upd_ready), 32'h1);
        reset = 1'b1;
        repeat (2 * FRAME_CYC) @(negedge clk_out);

        // 2: single update, shown after the next boundary
        wait_phase(20);
        offer({8'h06, 8'h5B, 8'h4F, 8'h66}, 1);
        chk("upd_ready_drop", 32'(upd_bus.upd_ready), 32'h0);
        wait_phase(0);
        wait_phase(6);
        chk("digit0_pattern", 32'(display_out), 32'h0000_0099);
        chk("digit0_select", 32'(seg_control), 32'h0000_000E);
        chk("upd_ready_back", 32'(upd_bus.upd_ready), 32'h1);

        // 3: PWM at full, quarter and zero brightness, one frame each
        wait_phase(0);
        brightness = 2'd3;
        repeat (FRAME_CYC) @(negedge clk_out);
        brightness = 2'd1;
        repeat (FRAME_CYC) @(negedge clk_out);
        brightness = 2'd0;
        repeat (FRAME_CYC) @(negedge clk_out);
        brightness = 2'd3;

        // 4: blink digit 1, disable digit 2, four frames
        blink_mask = 4'b0010;
        digit_en   = 4'b1011;
        repeat (4 * FRAME_CYC) @(negedge clk_out);
        blink_mask = '0;
        digit_en   = '1;

        // 5: offer in the boundary cycle, then a second offer held while full
        wait_phase(FRAME_CYC - 1);
        offer({8'h3F, 8'h06, 8'h5B, 8'h4F}, 1);
        chk("bnd_capture_held", 32'(upd_bus.upd_ready), 32'h0);
        upd_bus.digits_in = {8'h66, 8'h6D, 8'h7D, 8'h07};
        upd_bus.upd_valid = 1'b1;
        wait_phase(FRAME_CYC - 1);
        chk("second_offer_wait", 32'(upd_bus.upd_ready), 32'h0);
        repeat (2) @(negedge clk_out);
        upd_bus.upd_valid = 1'b0;
        repeat (2 * FRAME_CYC) @(negedge clk_out);

        // 6: reset at slot offset 9 of digit 2
        wait_phase(2 * SD + 9);
        chk("pre_rst_select", 32'(seg_control), 32'h0000_000B);
        reset = 1'b0;
        #1;
        chk("midrst_seg_control", 32'(seg_control), 32'h0000_000F);
        chk("midrst_display_out", 32'(display_out), 32'h0000_00FF);
        chk("midrst_upd_ready", 32'(upd_bus.upd_ready), 32'h1);
        repeat (2) @(negedge clk_out);
        reset = 1'b1;
        repeat (FRAME_CYC) @(negedge clk_out);

        // Randomized content, brightness, enable and blink
        for (int it = 0; it < 30; it++) begin
            brightness = BW'($urandom_range(0, BRT_FULL));
            digit_en   = ND'($urandom);
            blink_mask = ND'($urandom);
            if ($urandom_range(0, 2) != 0)
                offer({$urandom, $urandom}, $urandom_range(1, 3));
            repeat ($urandom_range(10, 80)) @(negedge clk_out);
        end

        repeat (2) @(negedge clk_out);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
